// File: rtl/iser_fco_pkg.sv
// Shared types and width helpers for the FCO frame aligner.
package iser_fco_pkg;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} fco_state_e;

  localparam int FCO_ERR_W = 8;

  function automatic int pos_w(input int din_w);
    return (din_w <= 2) ? 1 : $clog2(din_w);
  endfunction

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/iser_fco_edge_det.sv
// Thermometer decode of the last previous FCO bit plus the newest word:
// finds where the frame clock rises inside the word.
module iser_fco_edge_det
  import iser_fco_pkg::*;
#(
  parameter  int DIN_W = 2,
  localparam int POS_W = pos_w(DIN_W)
) (
  input  logic             d2_lsb,
  input  logic [DIN_W-1:0] d1,
  output logic             hit,
  output logic [POS_W-1:0] pos
);

  // A rise after p bits looks like p zeros followed by ones, with the
  // preceding bit low so a steady-high word is not mistaken for an edge.
  always_comb begin
    hit = 1'b0;
    pos = '0;
    for (int p = 0; p < DIN_W; p++) begin
      if (!d2_lsb && (d1 == ({DIN_W{1'b1}} >> p))) begin
        hit = 1'b1;
        pos = POS_W'(p);
      end
    end
  end

endmodule

// File: rtl/iser_fco_align.sv
// FCO frame aligner: searches for the frame-clock edge, verifies it over
// several frames, then flywheels a frame strobe while tracking bad frames.
module iser_fco_align
  import iser_fco_pkg::*;
#(
  parameter  int DIN_W      = 2,
  parameter  int FRAME_CLKS = 4,
  parameter  int LOCK_CNT   = 4,
  parameter  int MISS_MAX   = 2,
  parameter  int RDY_DLY    = 3,
  localparam int POS_W      = pos_w(DIN_W)
) (
  input  logic                 fco_dclk,
  input  logic                 fco_rst_n,
  input  logic                 fco_dclk_rdy,
  input  logic [DIN_W-1:0]     fco_din,
  input  logic                 fco_resync,
  output logic                 fco_strobe,
  output logic [POS_W-1:0]     fco_position,
  output logic                 fco_ready,
  output logic                 fco_locked,
  output logic [FCO_ERR_W-1:0] fco_err_cnt
);

  localparam int FW = cnt_width(FRAME_CLKS - 1);
  localparam int GW = cnt_width(LOCK_CNT);
  localparam int MW = cnt_width(MISS_MAX);

  localparam logic [FW-1:0] FCNT_WRAP = FW'(FRAME_CLKS - 1);
  localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_CNT);
  localparam logic [MW-1:0] MISS_DROP = MW'(MISS_MAX);

  fco_state_e         state;
  logic [RDY_DLY-1:0] rdy_sr;
  logic [DIN_W-1:0]   d1;
  logic               d2_lsb;
  logic [POS_W-1:0]   cand_pos;
  logic [FW-1:0]      fcnt;
  logic [GW-1:0]      good;
  logic [MW-1:0]      miss;
  logic               bad_seen;

  logic               hit;
  logic [POS_W-1:0]   hit_pos;
  logic               ce;
  logic               wrap;
  logic [FW-1:0]      fcnt_nxt;
  logic [GW-1:0]      good_inc;
  logic [MW-1:0]      miss_inc;

  // Only bit 0 of the older word matters to the edge decode.
  iser_fco_edge_det #(.DIN_W(DIN_W)) u_edge_det (
    .d2_lsb (d2_lsb),
    .d1     (d1),
    .hit    (hit),
    .pos    (hit_pos)
  );

  assign ce        = fco_dclk_rdy;
  assign fco_ready = rdy_sr[RDY_DLY-1];
  assign wrap      = (fcnt == FCNT_WRAP);
  assign fcnt_nxt  = wrap ? '0 : fcnt + FW'(1);
  assign good_inc  = good + GW'(1);
  assign miss_inc  = miss + MW'(1);

  // A hit seen mid-frame marks the frame bad; the verdict (and the single
  // error count for that frame) is taken at the wrap cycle.
  always_ff @(posedge fco_dclk or negedge fco_rst_n) begin
    if (!fco_rst_n) begin
      state        <= SEARCH;
      rdy_sr       <= '0;
      d1           <= '0;
      d2_lsb       <= 1'b0;
      cand_pos     <= '0;
      fcnt         <= '0;
      good         <= '0;
      miss         <= '0;
      bad_seen     <= 1'b0;
      fco_strobe   <= 1'b0;
      fco_position <= '0;
      fco_locked   <= 1'b0;
      fco_err_cnt  <= '0;
    end else begin
      fco_strobe <= 1'b0;
      if (ce) begin
        rdy_sr <= (rdy_sr << 1) | RDY_DLY'(1);
        d1     <= fco_din;
        d2_lsb <= d1[0];
        if (fco_resync) begin
          state       <= SEARCH;
          fcnt        <= '0;
          good        <= '0;
          miss        <= '0;
          bad_seen    <= 1'b0;
          fco_err_cnt <= '0;
          fco_locked  <= 1'b0;
        end else if (fco_ready) begin
          case (state)
            SEARCH: begin
              if (hit) begin
                cand_pos <= hit_pos;
                fcnt     <= '0;
                good     <= '0;
                state    <= VERIFY;
              end
            end
            VERIFY: begin
              if (wrap) begin
                fcnt <= '0;
                if (hit && (hit_pos == cand_pos)) begin
                  good <= good_inc;
                  if (good_inc == GOOD_LOCK) begin
                    state        <= LOCKED;
                    fco_position <= cand_pos;
                    fco_locked   <= 1'b1;
                    miss         <= '0;
                    bad_seen     <= 1'b0;
                  end
                end else begin
                  state <= SEARCH;
                end
              end else if (hit) begin
                state <= SEARCH;
              end else begin
                fcnt <= fcnt_nxt;
              end
            end
            LOCKED: begin
              fcnt <= fcnt_nxt;
              if (wrap) begin
                fco_strobe <= 1'b1;
                bad_seen   <= 1'b0;
                if (hit && (hit_pos == fco_position) && !bad_seen) begin
                  miss <= '0;
                end else begin
                  if (fco_err_cnt != '1) fco_err_cnt <= fco_err_cnt + FCO_ERR_W'(1);
                  if (miss_inc == MISS_DROP) begin
                    state      <= SEARCH;
                    fco_locked <= 1'b0;
                    miss       <= '0;
                  end else begin
                    miss <= miss_inc;
                  end
                end
              end else if (hit) begin
                bad_seen <= 1'b1;
              end
            end
            default: state <= SEARCH;
          endcase
        end
      end
    end
  end

endmodule
